// File: rtl/fifo_ctrl.sv
// fifo_ctrl: sequencing controller for the byte FIFO.
//
// Two producers share the FIFO write port through an arbiter. One consumer
// drains the FIFO through a registered valid/ready output stage. The access
// pattern keeps the FIFO within its rules:
//   - never push in two back-to-back cycles;
//   - never pop an empty or just-filled FIFO;
//   - give the head data SETTLE cycles before it is popped.
//
// Configuration macro: FIFO_CTRL_RR_EN
//   defined   -> round-robin arbitration between the two requesters
//   undefined -> fixed priority, requester 0 wins (requester 1 can starve)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in0_valid/in0_data/in0_ready  requester 0 (ready = granted this cycle)
//   in1_valid/in1_data/in1_ready  requester 1
//   fifo_push_back, fifo_data_in  FIFO write port
//   fifo_pop_front, fifo_data_out FIFO read port
//   fifo_empty/full/error         FIFO status
//   out_valid, out_data, out_ready registered consumer interface
//   err                           sticky: fifo_error was seen high
module fifo_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 2   // legal range 2..7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             fifo_push_back,
    output logic [WIDTH-1:0] fifo_data_in,
    output logic             fifo_pop_front,
    input  logic [WIDTH-1:0] fifo_data_out,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    input  logic             fifo_error,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             err
);

    localparam logic [2:0] SettleCnt = 3'(SETTLE);

    logic             push_q;
    logic [2:0]       stable_cnt;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             err_q;

    logic             push_ok;
    logic             grant0;
    logic             grant1;
    logic             can_load;
    logic             pop;

`ifdef FIFO_CTRL_RR_EN
    // 1 = requester 1 was granted last, so requester 0 wins the next tie.
    logic last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant0 || grant1) begin
            last_grant <= grant1;
        end
    end
`endif

    // Write side: combinational grant, one push at most every other cycle.
    always_comb begin
        push_ok = !rst && !push_q && !fifo_full;
        grant0  = 1'b0;
        grant1  = 1'b0;
        if (push_ok) begin
`ifdef FIFO_CTRL_RR_EN
            if (in0_valid && in1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = in0_valid;
                grant1 = in1_valid;
            end
`else
            grant0 = in0_valid;
            grant1 = in1_valid && !in0_valid;
`endif
        end
    end

    always_comb begin
        in0_ready      = grant0;
        in1_ready      = grant1;
        fifo_push_back = grant0 || grant1;
        if (grant0) begin
            fifo_data_in = in0_data;
        end else if (grant1) begin
            fifo_data_in = in1_data;
        end else begin
            fifo_data_in = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            push_q <= 1'b0;
        end else begin
            push_q <= fifo_push_back;
        end
    end

    // Read side: the head must sit non-empty and unpopped for SETTLE cycles.
    always_comb begin
        can_load       = !out_valid_q || out_ready;
        pop            = !rst && (stable_cnt == SettleCnt) && !fifo_empty && can_load;
        fifo_pop_front = pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_cnt <= 3'd0;
        end else if (fifo_empty || pop) begin
            stable_cnt <= 3'd0;
        end else if (stable_cnt != SettleCnt) begin
            stable_cnt <= stable_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_data_q  <= fifo_data_out;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q || fifo_error;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a 4-deep behavioural byte FIFO that flags illegal
// accesses on fifo_error. Expected output bytes go into exp_q when stimulus
// is issued; a monitor compares them at each output handshake.
module tb_fifo_ctrl;

    localparam int Depth = 4;

    logic       clk;
    logic       rst;
    logic       in0_valid, in1_valid;
    logic [7:0] in0_data, in1_data;
    logic       in0_ready, in1_ready;
    logic       fifo_push_back, fifo_pop_front;
    logic [7:0] fifo_data_in, fifo_data_out;
    logic       fifo_empty, fifo_full, fifo_error;
    logic       out_valid, out_ready, err;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    fifo_ctrl #(.WIDTH(8), .SETTLE(2)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .fifo_push_back(fifo_push_back), .fifo_data_in(fifo_data_in),
        .fifo_pop_front(fifo_pop_front), .fifo_data_out(fifo_data_out),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_error(fifo_error),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .err(err)
    );

    // Behavioural FIFO.
    logic [7:0] mem [Depth];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] count;
    logic       empty_prev, push_prev;
    logic       do_push, do_pop;

    assign fifo_empty    = (count == 3'd0);
    assign fifo_full     = (count == 3'(Depth));
    assign fifo_data_out = mem[rd_ptr];
    assign do_push       = fifo_push_back && !fifo_full;
    assign do_pop        = fifo_pop_front && !fifo_empty;

    always @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            count      <= 3'd0;
            fifo_error <= 1'b0;
            empty_prev <= 1'b1;
            push_prev  <= 1'b0;
        end else begin
            fifo_error <= (fifo_push_back && (push_prev || fifo_full)) ||
                          (fifo_pop_front && (fifo_empty || empty_prev));
            if (do_push) begin
                mem[wr_ptr] <= fifo_data_in;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 2'd1;
            count      <= count + {2'b0, do_push} - {2'b0, do_pop};
            empty_prev <= fifo_empty;
            push_prev  <= fifo_push_back;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Output monitor: handshake data, hold stability, push spacing.
    initial begin : monitor
        logic       prev_push;
        logic       hold_v;
        logic [7:0] hold_d;
        logic [7:0] e;
        prev_push = 1'b0;
        hold_v    = 1'b0;
        hold_d    = 8'h00;
        forever begin
            @(negedge clk);
            if (fifo_push_back) check("push_spacing", {31'b0, prev_push}, 32'd0);
            prev_push = fifo_push_back;
            if (hold_v) check("out_hold", {23'b0, out_valid, out_data}, {23'b0, 1'b1, hold_d});
            hold_v = out_valid && !out_ready && !rst;
            hold_d = out_data;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL out_unexpected: got %0h, expected no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {24'b0, out_data}, {24'b0, e});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic send(input int port, input logic [7:0] d);
        int k;
        logic rdy;
        k = 0;
        if (port == 0) begin in0_valid = 1'b1; in0_data = d; end
        else begin in1_valid = 1'b1; in1_data = d; end
        do begin
            @(negedge clk);
            k++;
            rdy = (port == 0) ? in0_ready : in1_ready;
        end while (!rdy && k < 200);
        check("grant_seen", {31'b0, rdy}, 32'd1);
        @(posedge clk); #1;
        if (port == 0) in0_valid = 1'b0;
        else in1_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drain_left", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_rr [6];
        logic [7:0] exp_fp [6];
        exp_rr = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        exp_fp = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

        // Reset: a pending request must not be granted while rst is high.
        rst = 1'b1; in0_valid = 1'b1; in0_data = 8'hEE;
        in1_valid = 1'b0; in1_data = 8'h00; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", {24'b0, out_data}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_in0_ready", {31'b0, in0_ready}, 32'd0);
        check("rst_push", {31'b0, fifo_push_back}, 32'd0);
        check("rst_pop", {31'b0, fifo_pop_front}, 32'd0);
        in0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single transfer latency: grant at t, pop at t+3, out_valid at t+4.
        exp_q.push_back(8'hA5);
        in0_valid = 1'b1; in0_data = 8'hA5;
        @(negedge clk);
        check("t1_ready_t", {31'b0, in0_ready}, 32'd1);
        @(posedge clk); #1;
        in0_valid = 1'b0;
        @(negedge clk);
        check("t1_pop_t1", {31'b0, fifo_pop_front}, 32'd0);
        @(negedge clk);
        check("t1_pop_t2", {31'b0, fifo_pop_front}, 32'd0);
        @(negedge clk);
        check("t1_pop_t3", {31'b0, fifo_pop_front}, 32'd1);
        @(negedge clk);
        check("t1_valid_t4", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'hA5});
        wait_drain();
        check("t1_err", {31'b0, err}, 32'd0);

        // Both requesters valid; fresh reset so requester 0 wins the first tie.
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
`ifdef FIFO_CTRL_RR_EN
            exp_q.push_back(exp_rr[i]);
`else
            exp_q.push_back(exp_fp[i]);
`endif
        end
        fork
            begin
                for (int i = 0; i < 3; i++) send(0, 8'h10 + 8'(i));
            end
            begin
                for (int j = 0; j < 3; j++) send(1, 8'h20 + 8'(j));
            end
        join
        wait_drain();

        // Requester 0 continuously valid: ready pattern 1,0,1,0.
        do_reset(2);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h30);
        in0_valid = 1'b1; in0_data = 8'h30;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t3_ready_pattern", {31'b0, in0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        in0_valid = 1'b0;
        wait_drain();

        // Stall output, fill FIFO, then release.
        do_reset(2);
        out_ready = 1'b0;
        for (int i = 0; i <= Depth; i++) exp_q.push_back(8'(i));
        for (int i = 0; i <= Depth; i++) send(0, 8'(i));
        @(negedge clk);
        check("t4_held", {23'b0, out_valid, out_data}, {23'b0, 1'b1, 8'h00});
        check("t4_full", {31'b0, fifo_full}, 32'd1);
        @(posedge clk); #1;
        in0_valid = 1'b1; in0_data = 8'h77;
        in1_valid = 1'b1; in1_data = 8'h78;
        repeat (4) begin
            @(negedge clk);
            check("t4_no_grant", {30'b0, in0_ready, in1_ready}, 32'd0);
        end
        @(posedge clk); #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("t4_err", {31'b0, err}, 32'd0);

        // Toggling out_ready with a 6-entry burst.
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h40 + 8'(i));
        fork
            begin
                for (int i = 0; i < 6; i++) send(0, 8'h40 + 8'(i));
            end
            begin
                repeat (40) begin @(posedge clk); #1; out_ready = ~out_ready; end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset mid-operation discards FIFO and held output.
        out_ready = 1'b0;
        send(0, 8'h61);
        send(0, 8'h62);
        send(0, 8'h63);
        repeat (3) @(negedge clk);
        check("t6_held_before_rst", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_after_rst", {30'b0, out_valid, fifo_pop_front}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send(0, 8'h5A);
        wait_drain();
        repeat (6) @(negedge clk);
        check("final_err", {31'b0, err}, 32'd0);
        check("final_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
